sobel_edge_stage: RTL and testbench
===================================

# sobel_edge_stage

Upstream pre-processing stage for the Hough transform core: converts each 24-bit RGB AXI4-Stream pixel to 8-bit luma, applies a 3x3 Sobel operator through two on-chip line buffers, and emits a binary edge map (24'hFFFFFF edge, 24'h000000 background) at one output beat per input beat. Its master stream drives the Hough core's slave stream directly, with the same video framing: tuser marks SOF, tlast marks EOL.

## Interface
- IMG_WIDTH, 640: active pixels per line.
- IMG_HEIGHT, 480: lines per frame.
- EDGE_THRESHOLD, 128: edge decision threshold on the 12-bit gradient magnitude.
- ap_clk  in  1  single clock; all logic rising-edge.
- aresetn  in  1  reset, asynchronous assert, active-low.
- s_axis_tdata  in  24  RGB pixel, {R[23:16], G[15:8], B[7:0]}.
- s_axis_tvalid  in  1  input beat valid.
- s_axis_tready  out  1  input beat accepted when high with tvalid.
- s_axis_tlast  in  1  last pixel of line.
- s_axis_tuser  in  1  first pixel of frame (SOF).
- m_axis_tdata  out  24  edge pixel.
- m_axis_tvalid  out  1  output beat valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  EOL, delayed copy of the input tlast.
- m_axis_tuser  out  1  SOF, delayed copy of the input tuser.
- frame_err  out  1  sticky flag: a line length or frame length did not match the parameters.

## Operation
- FSM states:
  - WAIT_SOF (reset state): input beats are accepted and discarded until a beat with tuser=1.
  - ACTIVE: that SOF beat enters the pipeline at x=0, y=0.
- Counters: x in 0..IMG_WIDTH-1, y in 0..IMG_HEIGHT-1, both advanced per accepted beat.
  - x wraps to 0 on tlast or when x reaches IMG_WIDTH-1, whichever comes first.
  - If the two disagree, frame_err is set.
  - y increments on each x wrap.
  - When the last pixel of the frame (x=IMG_WIDTH-1, y=IMG_HEIGHT-1) is accepted, FSM returns to WAIT_SOF.
- Mid-frame SOF: a tuser=1 beat in ACTIVE sets frame_err and restarts the counters at x=0, y=0. Line-buffer contents are kept; border masking covers them.
- Luma: Y = (77*R + 150*G + 29*B) >> 8, computed in a 16-bit intermediate with an 8-bit result.
- Window: a 3x3 window is formed from the two line buffers (rows y-2 and y-1) plus the current row. The window's bottom-right sample is pixel (x,y).
- Sobel:
  - Gx = (p02 + 2*p12 + p22) - (p00 + 2*p10 + p20), 11-bit signed.
  - Gy is the same with rows and columns swapped.
  - mag = |Gx| + |Gy|, 12-bit unsigned, maximum 2040.
- Output pixel for input beat (x,y) is the gradient centred at (x-1,y-1), giving a fixed one-pixel shift. Beats with x<2 or y<2 output 24'h000000.
- Output value is 24'hFFFFFF when mag >= EDGE_THRESHOLD, else 24'h000000.
- tuser and tlast travel alongside their pixel through every pipeline stage.

## Timing
- Pipeline stages: S0 luma, S1 window/line-buffer update, S2 Gx/Gy, S3 magnitude/threshold and output register. Each stage has a valid bit.
- advance = m_axis_tready | ~v3. All stages shift when advance=1 and hold otherwise.
- s_axis_tready = advance while out of reset; this is a combinational path from m_axis_tready by design.
- Latency: an accepted beat appears on m_axis 3 cycles later when there is no backpressure.
- Throughput: 1 pixel/cycle.
- AXI rule: m_axis_tdata, tlast and tuser are stable while m_axis_tvalid=1 and m_axis_tready=0.
- Line buffers: read and write in the same advance cycle at address x. Read-before-write; a single-port RAM with synchronous read is sufficient.
- Reset values: m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, m_axis_tuser=0, s_axis_tready=0, frame_err=0, FSM=WAIT_SOF, counters=0, valid bits=0.
- Reset mid-frame: in-flight beats are lost and the next frame must begin with SOF. Line-buffer RAM contents are not cleared.

## Configuration
- SOBEL_MAG_OUT_EN:
  - Defined: m_axis_tdata = {m8,m8,m8}, where m8 = mag saturated to 255; EDGE_THRESHOLD is ignored. Used for debug viewing.
  - Undefined: binary edge output as above.
- Latency, border masking and framing are identical in both builds.

## Structure
- Package hough_pkg holds:
  - PIX_W=24 and LUMA_W=8;
  - the luma coefficients 77/150/29;
  - the GRAD_W=11 and MAG_W=12 widths;
  - the FSM state typedef (WAIT_SOF, ACTIVE).
- Sub-module sobel_line_buffer: a parameterised IMG_WIDTH x 8 RAM with enable, instantiated twice.

## Test plan
- Flat frame of 24'h808080 -> every output is 24'h000000; the first output arrives 3 cycles after acceptance with tuser=1; tlast appears on every 640th beat.
- Vertical step (x<320 = 24'h000000, x>=320 = 24'hFFFFFF) -> for y>=2, the outputs at x=320 and x=321 are 24'hFFFFFF (mag=1020) and all other outputs are 0.
- Same step with m_axis_tready toggled pseudo-randomly at 50% -> output stream is identical to the no-stall run, with no beat lost or duplicated, and data stays stable during stalls.
- 5 garbage beats before SOF -> all are discarded; the output frame matches the clean-frame result exactly.
- tlast at beat 600 of line 3 -> frame_err=1 and stays high; the counters resync to x=0 on the next line.
- aresetn pulsed low for 1 cycle during line 100 -> all outputs are at their reset values; after a new SOF the full frame of 307200 beats is output correctly.

Source files
------------

// File: rtl/hough_pkg.sv
// hough_pkg: shared widths, luma coefficients, FSM state type and small
// arithmetic helpers for the Sobel pre-processing stage.
package hough_pkg;

    localparam int PIX_W   = 24;
    localparam int LUMA_W  = 8;

    // ITU-R BT.601 style luma weights, scaled by 256
    localparam int LUMA_CR = 77;
    localparam int LUMA_CG = 150;
    localparam int LUMA_CB = 29;

    localparam int GRAD_W  = 11;
    localparam int MAG_W   = 12;
    // a + 2b + c of three luma samples, always non-negative
    localparam int SUM_W   = LUMA_W + 2;

    typedef enum logic [0:0] {
        WAIT_SOF = 1'b0,
        ACTIVE   = 1'b1
    } state_t;

    // Y = (77R + 150G + 29B) >> 8; the weights sum to 256 so 16 bits never overflow
    function automatic logic [LUMA_W-1:0] rgb_to_luma(input logic [PIX_W-1:0] rgb);
        logic [15:0] acc;
        acc = 16'(LUMA_CR) * {8'd0, rgb[23:16]}
            + 16'(LUMA_CG) * {8'd0, rgb[15:8]}
            + 16'(LUMA_CB) * {8'd0, rgb[7:0]};
        return acc[15:8];
    endfunction

    // One side of a Sobel kernel: a + 2*b + c
    function automatic logic [SUM_W-1:0] tap_sum(input logic [LUMA_W-1:0] a,
                                                 input logic [LUMA_W-1:0] b,
                                                 input logic [LUMA_W-1:0] c);
        return {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
    endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// sobel_line_buffer: one video line of luma samples. Single port with
// synchronous read-before-write: rdata returns the old word at addr while
// the new word is written in the same enabled cycle. Contents are never reset.
module sobel_line_buffer
    import hough_pkg::*;
#(
    parameter int IMG_WIDTH = 640,
    parameter int AW        = $clog2(IMG_WIDTH)
) (
    input  logic              ap_clk,
    input  logic              en,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [LUMA_W-1:0] wdata,
    output logic [LUMA_W-1:0] rdata
);

    logic [LUMA_W-1:0] mem [IMG_WIDTH];

    // Read old contents, then overwrite when write-enabled; hold rdata when idle
    always_ff @(posedge ap_clk) begin
        if (en) begin
            rdata <= mem[addr];
            if (we) begin
                mem[addr] <= wdata;
            end
        end
    end

endmodule

// File: rtl/sobel_edge_stage.sv
// sobel_edge_stage: RGB pixel stream -> 8-bit luma -> 3x3 Sobel gradient ->
// binary edge map, one output beat per input beat, 3 cycles latency.
// Build macro SOBEL_MAG_OUT_EN: emit the saturated gradient magnitude as a
// grey pixel instead of the thresholded edge map (debug viewing).
//
// Handshake: a beat transfers on a rising edge where tvalid and tready are
// both high. All four stages shift together when advance = m_axis_tready | ~v3
// and hold otherwise, so m_axis_* stays stable while valid is high and ready
// low; s_axis_tready is advance itself (combinational from m_axis_tready).
//
// Line buffers are selected by row parity: the buffer matching the parity of
// the current row holds row y-2 (read) and is overwritten with row y, the
// other buffer holds row y-1. The first two rows/columns of every frame are
// masked to background, which also hides stale buffer contents.
module sobel_edge_stage
    import hough_pkg::*;
#(
    parameter int IMG_WIDTH      = 640,
    parameter int IMG_HEIGHT     = 480,
    parameter int EDGE_THRESHOLD = 128
) (
    input  logic             ap_clk,
    input  logic             aresetn,
    input  logic [PIX_W-1:0] s_axis_tdata,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    input  logic             s_axis_tlast,
    input  logic             s_axis_tuser,
    output logic [PIX_W-1:0] m_axis_tdata,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic             m_axis_tlast,
    output logic             m_axis_tuser,
    output logic             frame_err,
    output state_t           fsm_state
);

    localparam int XW = $clog2(IMG_WIDTH);
    localparam int YW = $clog2(IMG_HEIGHT);

    // ------------------------------------------------------------------
    // Flow control
    // ------------------------------------------------------------------
    logic run;
    logic v0, v1, v2, v3;
    logic advance;
    logic acc;

    assign advance       = m_axis_tready | ~v3;
    assign s_axis_tready = run & advance;
    assign acc           = s_axis_tvalid & s_axis_tready;

    // Hold the input closed until the first clock after reset release
    always_ff @(posedge ap_clk or negedge aresetn) begin
        if (!aresetn) run <= 1'b0;
        else          run <= 1'b1;
    end

    // ------------------------------------------------------------------
    // Framing FSM and x/y counters
    // ------------------------------------------------------------------
    state_t          state, state_nx;
    logic [XW-1:0]   x_cnt, x_nx, bx;
    logic [YW-1:0]   y_cnt, y_nx, by;
    logic            err_nx;
    logic            take;
    logic            x_at_end;
    logic            line_end;

    assign fsm_state = state;

    // Next state: place the accepted beat at (bx,by), decide if it enters the pipe
    always_comb begin
        state_nx = state;
        x_nx     = x_cnt;
        y_nx     = y_cnt;
        err_nx   = frame_err;
        take     = 1'b0;
        bx       = x_cnt;
        by       = y_cnt;
        x_at_end = 1'b0;
        line_end = 1'b0;
        if (acc) begin
            if (s_axis_tuser) begin
                bx = '0;
                by = '0;
            end
            x_at_end = (bx == XW'(IMG_WIDTH - 1));
            line_end = s_axis_tlast | x_at_end;
            case (state)
                WAIT_SOF: take = s_axis_tuser;
                ACTIVE: begin
                    take = 1'b1;
                    if (s_axis_tuser) err_nx = 1'b1;
                end
                default: take = 1'b0;
            endcase
            if (take) begin
                state_nx = ACTIVE;
                if (s_axis_tlast != x_at_end) err_nx = 1'b1;
                if (line_end) begin
                    x_nx = '0;
                    if (by == YW'(IMG_HEIGHT - 1)) begin
                        y_nx     = '0;
                        state_nx = WAIT_SOF;
                    end else begin
                        y_nx = by + 1'b1;
                    end
                end else begin
                    x_nx = bx + 1'b1;
                    y_nx = by;
                end
            end
        end
    end

    // FSM, counters and sticky framing error
    always_ff @(posedge ap_clk or negedge aresetn) begin
        if (!aresetn) begin
            state     <= WAIT_SOF;
            x_cnt     <= '0;
            y_cnt     <= '0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nx;
            x_cnt     <= x_nx;
            y_cnt     <= y_nx;
            frame_err <= err_nx;
        end
    end

    // ------------------------------------------------------------------
    // S0: luma conversion
    // ------------------------------------------------------------------
    logic [LUMA_W-1:0] luma0;
    logic [XW-1:0]     x0;
    logic              par0, border0, user0, last0;

    // Capture the accepted beat with its coordinates and border flag
    always_ff @(posedge ap_clk or negedge aresetn) begin
        if (!aresetn) begin
            v0      <= 1'b0;
            luma0   <= '0;
            x0      <= '0;
            par0    <= 1'b0;
            border0 <= 1'b0;
            user0   <= 1'b0;
            last0   <= 1'b0;
        end else if (advance) begin
            v0 <= take;
            if (take) begin
                luma0   <= rgb_to_luma(s_axis_tdata);
                x0      <= bx;
                par0    <= by[0];
                border0 <= (bx[XW-1:1] == '0) | (by[YW-1:1] == '0);
                user0   <= s_axis_tuser;
                last0   <= s_axis_tlast;
            end
        end
    end

    // ------------------------------------------------------------------
    // S1: line-buffer access; RAM read registers form part of this stage
    // ------------------------------------------------------------------
    logic              lb_en;
    logic [LUMA_W-1:0] q_even, q_odd;
    logic [LUMA_W-1:0] luma1;
    logic              par1, border1, user1, last1;

    assign lb_en = advance & v0;

    sobel_line_buffer #(.IMG_WIDTH(IMG_WIDTH), .AW(XW)) u_lb_even (
        .ap_clk (ap_clk),
        .en     (lb_en),
        .we     (~par0),
        .addr   (x0),
        .wdata  (luma0),
        .rdata  (q_even)
    );

    sobel_line_buffer #(.IMG_WIDTH(IMG_WIDTH), .AW(XW)) u_lb_odd (
        .ap_clk (ap_clk),
        .en     (lb_en),
        .we     (par0),
        .addr   (x0),
        .wdata  (luma0),
        .rdata  (q_odd)
    );

    // Carry the current-row sample and sidebands alongside the RAM reads
    always_ff @(posedge ap_clk or negedge aresetn) begin
        if (!aresetn) begin
            v1      <= 1'b0;
            luma1   <= '0;
            par1    <= 1'b0;
            border1 <= 1'b0;
            user1   <= 1'b0;
            last1   <= 1'b0;
        end else if (advance) begin
            v1 <= v0;
            if (v0) begin
                luma1   <= luma0;
                par1    <= par0;
                border1 <= border0;
                user1   <= user0;
                last1   <= last0;
            end
        end
    end

    // Column x of the window: top = row y-2, mid = row y-1, bottom = row y
    logic [LUMA_W-1:0] col_t, col_m, col_b;
    always_comb begin
        col_b = luma1;
        col_m = par1 ? q_even : q_odd;
        col_t = par1 ? q_odd  : q_even;
    end

    // ------------------------------------------------------------------
    // S2: Gx / Gy over columns x-2 (w2), x-1 (w1), x (col)
    // ------------------------------------------------------------------
    logic [LUMA_W-1:0]        w1_t, w1_m, w1_b, w2_t, w2_m, w2_b;
    logic signed [GRAD_W-1:0] gx_c, gy_c, gx2, gy2;
    logic                     border2, user2, last2;

    // Right column minus left column (Gx), bottom row minus top row (Gy)
    always_comb begin
        gx_c = $signed({1'b0, tap_sum(col_t, col_m, col_b)})
             - $signed({1'b0, tap_sum(w2_t, w2_m, w2_b)});
        gy_c = $signed({1'b0, tap_sum(w2_b, w1_b, col_b)})
             - $signed({1'b0, tap_sum(w2_t, w1_t, col_t)});
    end

    // Register gradients and slide the window by one column per valid beat
    always_ff @(posedge ap_clk or negedge aresetn) begin
        if (!aresetn) begin
            v2      <= 1'b0;
            gx2     <= '0;
            gy2     <= '0;
            border2 <= 1'b0;
            user2   <= 1'b0;
            last2   <= 1'b0;
            w1_t    <= '0;
            w1_m    <= '0;
            w1_b    <= '0;
            w2_t    <= '0;
            w2_m    <= '0;
            w2_b    <= '0;
        end else if (advance) begin
            v2 <= v1;
            if (v1) begin
                gx2     <= gx_c;
                gy2     <= gy_c;
                border2 <= border1;
                user2   <= user1;
                last2   <= last1;
                w2_t    <= w1_t;
                w2_m    <= w1_m;
                w2_b    <= w1_b;
                w1_t    <= col_t;
                w1_m    <= col_m;
                w1_b    <= col_b;
            end
        end
    end

    // ------------------------------------------------------------------
    // S3: magnitude, threshold and output register
    // ------------------------------------------------------------------
    logic [SUM_W-1:0] ax, ay;
    logic [MAG_W-1:0] mag_c;
    logic [PIX_W-1:0] pix_c;
`ifdef SOBEL_MAG_OUT_EN
    logic [LUMA_W-1:0] m8;
`endif

    // |Gx| + |Gy| (each at most 1020, so 10 bits hold the absolute value)
    always_comb begin
        ax    = gx2[GRAD_W-1] ? SUM_W'(-gx2) : SUM_W'(gx2);
        ay    = gy2[GRAD_W-1] ? SUM_W'(-gy2) : SUM_W'(gy2);
        mag_c = {2'b00, ax} + {2'b00, ay};
`ifdef SOBEL_MAG_OUT_EN
        m8    = (mag_c > MAG_W'(255)) ? 8'hFF : mag_c[LUMA_W-1:0];
        pix_c = {m8, m8, m8};
`else
        pix_c = (mag_c >= MAG_W'(EDGE_THRESHOLD)) ? {PIX_W{1'b1}} : '0;
`endif
        if (border2) pix_c = '0;
    end

    // Output register; holds under backpressure
    always_ff @(posedge ap_clk or negedge aresetn) begin
        if (!aresetn) begin
            v3           <= 1'b0;
            m_axis_tdata <= '0;
            m_axis_tlast <= 1'b0;
            m_axis_tuser <= 1'b0;
        end else if (advance) begin
            v3 <= v2;
            if (v2) begin
                m_axis_tdata <= pix_c;
                m_axis_tlast <= last2;
                m_axis_tuser <= user2;
            end
        end
    end

    assign m_axis_tvalid = v3;

endmodule

// File: tb/tb_sobel_edge_stage.sv
// tb_sobel_edge_stage: scoreboard bench for sobel_edge_stage on a reduced
// frame size. Expected pixels come from a direct 2D Sobel model of the frame.
module tb_sobel_edge_stage;
    import hough_pkg::*;

    localparam int W   = 24;
    localparam int H   = 10;
    localparam int THR = 128;
    localparam int EW  = 27;  // {check_data, tuser, tlast, tdata}

    // ---------------- clock / reset ----------------
    logic ap_clk = 1'b0;
    logic aresetn = 1'b0;
    always #5 ap_clk = ~ap_clk;

    int cyc = 0;
    always @(posedge ap_clk) cyc <= cyc + 1;

    // ---------------- DUT ----------------
    logic [23:0] s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic        s_axis_tlast = 1'b0;
    logic        s_axis_tuser = 1'b0;
    logic [23:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic        m_axis_tlast;
    logic        m_axis_tuser;
    logic        frame_err;
    state_t      fsm_state;

    sobel_edge_stage #(
        .IMG_WIDTH      (W),
        .IMG_HEIGHT     (H),
        .EDGE_THRESHOLD (THR)
    ) dut (
        .ap_clk        (ap_clk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tuser  (s_axis_tuser),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .frame_err     (frame_err),
        .fsm_state     (fsm_state)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [23:0] img [H][W];

    function automatic int luma_of(input logic [23:0] p);
        int r, g, b;
        r = int'(p[23:16]);
        g = int'(p[15:8]);
        b = int'(p[7:0]);
        return (77 * r + 150 * g + 29 * b) / 256;
    endfunction

    function automatic logic [23:0] exp_pix(input int x, input int y);
        int l [3][3];
        int gx, gy, mag;
        if (x < 2 || y < 2) return 24'h000000;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                l[r][c] = luma_of(img[y - 2 + r][x - 2 + c]);
        gx  = (l[0][2] + 2 * l[1][2] + l[2][2]) - (l[0][0] + 2 * l[1][0] + l[2][0]);
        gy  = (l[2][0] + 2 * l[2][1] + l[2][2]) - (l[0][0] + 2 * l[0][1] + l[0][2]);
        mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
`ifdef SOBEL_MAG_OUT_EN
        begin
            logic [7:0] m8;
            m8 = (mag > 255) ? 8'hFF : 8'(mag);
            return {m8, m8, m8};
        end
`else
        return (mag >= THR) ? 24'hFFFFFF : 24'h000000;
`endif
    endfunction

    // 0 flat grey, 1 vertical step, 2 random RGB, 3 grey noise near threshold
    task automatic make_img(input int pattern);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                logic [7:0] g;
                case (pattern)
                    0:       img[y][x] = 24'h808080;
                    1:       img[y][x] = (x < W / 2) ? 24'h000000 : 24'hFFFFFF;
                    2:       img[y][x] = 24'($urandom);
                    default: begin
                        g = 8'($urandom_range(100, 140));
                        img[y][x] = {g, g, g};
                    end
                endcase
            end
    endtask

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q [$];
    bit            stall_en = 1'b0;
    bit            lat_armed = 1'b0;
    int            sof_cyc = 0;

    // ---------------- driver tasks ----------------
    task automatic send_beat(input logic [23:0] d, input logic u, input logic l,
                             input logic push, input logic [EW-1:0] e);
        int n = 0;
        s_axis_tdata  = d;
        s_axis_tuser  = u;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        @(negedge ap_clk);
        while (!s_axis_tready && n < 1000) begin
            @(negedge ap_clk);
            n++;
        end
        if (!s_axis_tready) check("accept_timeout", {31'd0, s_axis_tready}, 32'd1);
        else if (push) exp_q.push_back(e);
        @(posedge ap_clk);
        #1;
        s_axis_tvalid = 1'b0;
    endtask

    task automatic send_frame(input bit chk, input int short_line, input int short_len,
                              input int abort_line);
        for (int y = 0; y < H; y++) begin
            int len;
            len = (y == short_line) ? short_len : W;
            if (y == abort_line) len = W / 2;
            for (int x = 0; x < len; x++) begin
                logic u, l, c;
                logic [EW-1:0] e;
                u = (x == 0 && y == 0);
                l = (x == len - 1) && (y != abort_line);
                c = chk && (short_line < 0 || y <= short_line);
                e = {c, u, l, exp_pix(x, y)};
                send_beat(img[y][x], u, l, 1'b1, e);
                if (u && !stall_en) begin
                    sof_cyc   = cyc;
                    lat_armed = 1'b1;
                end
            end
            if (y == abort_line) return;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 5000) begin
            @(negedge ap_clk);
            n++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
        @(posedge ap_clk);
        #1;
    endtask

    task automatic check_reset_values();
        check("rst_m_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
        check("rst_m_tdata", {8'd0, m_axis_tdata}, 32'd0);
        check("rst_m_tlast", {31'd0, m_axis_tlast}, 32'd0);
        check("rst_m_tuser", {31'd0, m_axis_tuser}, 32'd0);
        check("rst_s_tready", {31'd0, s_axis_tready}, 32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        check("rst_state", {31'd0, fsm_state}, {31'd0, WAIT_SOF});
    endtask

    task automatic end_of_frame(input logic err_exp);
        check("frame_err", {31'd0, frame_err}, {31'd0, err_exp});
        check("idle_state", {31'd0, fsm_state}, {31'd0, WAIT_SOF});
    endtask

    // ---------------- downstream ready ----------------
    always @(posedge ap_clk) begin
        #1;
        m_axis_tready = stall_en ? ($urandom_range(0, 1) == 1) : 1'b1;
    end

    // ---------------- output monitor ----------------
    logic          held = 1'b0;
    logic [25:0]   held_word = '0;
    logic [EW-1:0] e_mon;

    always @(negedge ap_clk) begin
        if (!aresetn) begin
            held = 1'b0;
        end else if (m_axis_tvalid) begin
            if (held)
                check("stall_stable", {6'd0, m_axis_tuser, m_axis_tlast, m_axis_tdata},
                      {6'd0, held_word});
            if (lat_armed && m_axis_tuser) begin
                check("sof_latency", 32'(cyc - sof_cyc), 32'd3);
                lat_armed = 1'b0;
            end
            if (m_axis_tready) begin
                held = 1'b0;
                if (exp_q.size() == 0) begin
                    check("spurious_beat", {31'd0, m_axis_tvalid}, 32'd0);
                end else begin
                    e_mon = exp_q.pop_front();
                    check("tuser", {31'd0, m_axis_tuser}, {31'd0, e_mon[25]});
                    check("tlast", {31'd0, m_axis_tlast}, {31'd0, e_mon[24]});
                    if (e_mon[26])
                        check("tdata", {8'd0, m_axis_tdata}, {8'd0, e_mon[23:0]});
                end
            end else begin
                held      = 1'b1;
                held_word = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
            end
        end else begin
            if (held) check("stall_valid", {31'd0, m_axis_tvalid}, 32'd1);
            held = 1'b0;
        end
    end

    // ---------------- test sequence ----------------
    initial begin
        repeat (3) @(posedge ap_clk);
        @(negedge ap_clk);
        check_reset_values();
        aresetn = 1'b1;
        @(posedge ap_clk);
        #1;

        // flat grey: no edges anywhere
        make_img(0);
        send_frame(1'b1, -1, 0, -1);
        drain();
        end_of_frame(1'b0);

        // vertical step, free-running output
        make_img(1);
        send_frame(1'b1, -1, 0, -1);
        drain();
        end_of_frame(1'b0);

        // same step under random backpressure
        stall_en = 1'b1;
        send_frame(1'b1, -1, 0, -1);
        drain();
        stall_en = 1'b0;
        end_of_frame(1'b0);

        // garbage before SOF is discarded, then a random frame
        make_img(2);
        for (int i = 0; i < 5; i++)
            send_beat(24'($urandom), 1'b0, 1'($urandom_range(0, 1)), 1'b0, '0);
        send_frame(1'b1, -1, 0, -1);
        drain();
        end_of_frame(1'b0);

        // grey noise around the threshold, with backpressure
        make_img(3);
        stall_en = 1'b1;
        send_frame(1'b1, -1, 0, -1);
        drain();
        stall_en = 1'b0;
        end_of_frame(1'b0);

        // early tlast on line 3: sticky error, counters resync on next line
        make_img(2);
        send_frame(1'b1, 3, W - 4, -1);
        drain();
        end_of_frame(1'b1);

        // clean frame afterwards decodes correctly, error stays set
        make_img(1);
        send_frame(1'b1, -1, 0, -1);
        drain();
        end_of_frame(1'b1);

        // reset pulse mid-frame, then a full fresh frame
        make_img(2);
        send_frame(1'b1, -1, 0, 4);
        aresetn = 1'b0;
        @(negedge ap_clk);
        check_reset_values();
        @(posedge ap_clk);
        #1;
        aresetn = 1'b1;
        exp_q.delete();
        make_img(3);
        send_frame(1'b1, -1, 0, -1);
        drain();
        end_of_frame(1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
